// File: rtl/rv_fifo.sv
// rv_fifo: parametrised valid/ready FIFO with occupancy count, almost-full
// flag and synchronous flush. Pointers carry one extra wrap bit so that full
// and empty are told apart without a separate counter register.
module rv_fifo #(
  parameter int wd    = 4,
  parameter int depth = 4,
  parameter int afull = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     datain_val,
  output logic                     datain_rdy,
  input  logic [wd-1:0]            datain,
  output logic                     dataout_val,
  input  logic                     dataout_rdy,
  output logic [wd-1:0]            dataout,
  output logic [$clog2(depth):0]   count,
  output logic                     almost_full
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] WRAP_BIT = {1'b1, {AW{1'b0}}};

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [wd-1:0] dout_q, dout_d;
  logic [wd-1:0] mem [depth];

  logic full, empty, push, pop;

  // Status flags come from registered pointers only, so neither ready nor
  // valid has a combinational path from the opposite side of the FIFO.
  always_comb begin
    empty       = (rd_q == wr_q);
    full        = ((rd_q ^ WRAP_BIT) == wr_q);
    datain_rdy  = ~full;
    dataout_val = ~empty;
    push        = datain_val & ~full;
    pop         = dataout_val & dataout_rdy;
    count       = wr_q - rd_q;
    almost_full = (int'(count) >= afull);
    dataout     = dout_q;
  end

  // Next pointers and next head word. The head is kept in its own register so
  // it can hold the last read value while empty (and is zero after reset).
  // A word pushed into a FIFO that becomes one-deep is forwarded straight into
  // the head register because the array write lands on the same edge.
  always_comb begin
    rd_d   = rd_q + {{AW{1'b0}}, pop};
    wr_d   = wr_q + {{AW{1'b0}}, push};
    dout_d = dout_q;
    if (flush) begin
      rd_d   = '0;
      wr_d   = '0;
      dout_d = '0;
    end else if (rd_d != wr_d) begin
      if (push && (rd_d == wr_q)) begin
        dout_d = datain;
      end else begin
        dout_d = mem[rd_d[AW-1:0]];
      end
    end
  end

  // Control state: pointers and head register, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      dout_q <= dout_d;
    end
  end

  // Storage array: not reset; a flush discards the word offered that cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_q[AW-1:0]] <= datain;
    end
  end

endmodule

// File: tb/tb_rv_fifo.sv
// tb_rv_fifo: directed and randomized checks of rv_fifo against a queue-based
// reference model of the FIFO contents.
module tb_rv_fifo;

  localparam int WD    = 4;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          datain_val;
  logic          datain_rdy;
  logic [WD-1:0] datain;
  logic          dataout_val;
  logic          dataout_rdy;
  logic [WD-1:0] dataout;
  logic [2:0]    count;
  logic          almost_full;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of stored words, plus the last word read out.
  int unsigned mq[$];
  int unsigned last_out;
  bit          last_known;

  rv_fifo #(.wd(WD), .depth(DEPTH), .afull(AFULL)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .datain_val  (datain_val),
    .datain_rdy  (datain_rdy),
    .datain      (datain),
    .dataout_val (dataout_val),
    .dataout_rdy (dataout_rdy),
    .dataout     (dataout),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", count, mq.size());
    chk("dataout_val", dataout_val, (mq.size() != 0));
    chk("datain_rdy", datain_rdy, (mq.size() != DEPTH));
    chk("almost_full", almost_full, (mq.size() >= AFULL));
    if (mq.size() != 0) chk("dataout", dataout, mq[0]);
    else if (last_known) chk("dataout_hold", dataout, last_out);
  endtask

  // One clock cycle: apply inputs, check outputs, advance model on the edge.
  task automatic cycle(input bit v, input bit r, input int unsigned d, input bit f);
    bit do_push, do_pop;
    datain_val  = v;
    dataout_rdy = r;
    datain      = WD'(d);
    flush       = f;
    check_state();
    do_push = v && (mq.size() < DEPTH);
    do_pop  = r && (mq.size() > 0);
    @(posedge clk);
    if (f) begin
      mq.delete();
      last_known = 1'b0;
    end else begin
      if (do_pop) begin
        last_out   = mq.pop_front();
        last_known = 1'b1;
      end
      if (do_push) mq.push_back(d & 32'hF);
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic reset_mid();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_dataout_val", dataout_val, 0);
    chk("rst_datain_rdy", datain_rdy, 1);
    chk("rst_count", count, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_dataout", dataout, 0);
    mq.delete();
    last_out   = 0;
    last_known = 1'b1;
    datain_val  = 1'b0;
    dataout_rdy = 1'b0;
    flush       = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; datain_val = 1'b0; dataout_rdy = 1'b0; datain = '0;
    last_out = 0; last_known = 1'b1;
    reset_mid();

    // Fill then drain
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, i, 0);
      chk("fill_count", count, i);
    end
    chk("fill_afull", almost_full, 1);
    chk("fill_rdy", datain_rdy, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", dataout, i);
      cycle(0, 1, 0, 0);
    end
    chk("drain_empty", dataout_val, 0);

    // Streaming through pointer wrap
    for (int i = 1; i <= 8; i++) cycle(1, 1, i, 0);
    chk("stream_count", count, 1);
    cycle(0, 1, 0, 0);

    // Full with simultaneous valid and ready
    for (int i = 1; i <= 4; i++) cycle(1, 0, i + 4, 0);
    cycle(1, 1, 9, 0);
    chk("full_no_push", count, 3);
    cycle(1, 1, 9, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

    // Flush overriding a push
    for (int i = 1; i <= 3; i++) cycle(1, 0, i, 0);
    cycle(1, 0, 5, 1);
    chk("flush_count", count, 0);
    chk("flush_val", dataout_val, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);

    // Reset in the middle of traffic
    for (int i = 1; i <= 2; i++) cycle(1, 0, i + 10, 0);
    reset_mid();

    // Random back-pressure
    for (int i = 0; i < 1000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15), $urandom_range(0, 63) == 0);
    end
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
